memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache miss path and the data-cache miss/writeback path of the Abejaruco core.
- Latches one request at a time, drives a multi-cycle memory transaction and returns the line to the winning requester with a one-cycle ready pulse.
- Uses round-robin arbitration on simultaneous requests, so a load-heavy program cannot starve instruction fetch.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- LINE_WIDTH, 128, cache line width in bits; memory transfers whole lines.
- OFFSET_BITS, 4, log2(LINE_WIDTH/8); these low address bits are forced to zero on mem_addr.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- icache_req  input  1  I-cache line-fill request, held until icache_ready.
- icache_addr  input  ADDRESS_WIDTH  I-cache miss address.
- icache_ready  output  1  one-cycle pulse: icache_line valid.
- icache_line  output  LINE_WIDTH  fill data for the I-cache.
- dcache_req  input  1  D-cache request, held until dcache_ready.
- dcache_we  input  1  1 = writeback of dcache_wdata, 0 = line fill.
- dcache_addr  input  ADDRESS_WIDTH  D-cache address.
- dcache_wdata  input  LINE_WIDTH  writeback line.
- dcache_ready  output  1  one-cycle pulse: fill data valid or writeback done.
- dcache_line  output  LINE_WIDTH  fill data for the D-cache.
- mem_req  output  1  memory transaction active.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDRESS_WIDTH  line-aligned address.
- mem_wdata  output  LINE_WIDTH  write data.
- mem_rdata  input  LINE_WIDTH  read data, valid with mem_ready.
- mem_ready  input  1  one-cycle completion pulse from memory.

Behaviour:
- Reset asserted (reset=0), at any time:
  - state=IDLE, last_grant=DCACHE, so the I-cache wins the first tie.
  - All outputs are 0, including all data buses.
  - Any in-flight memory transaction is abandoned and mem_req drops immediately.
- FSM states: IDLE, BUSY_I, BUSY_D, RELEASE.
- IDLE:
  - Only icache_req high -> BUSY_I.
  - Only dcache_req high -> BUSY_D.
  - Both high -> grant the requester not equal to last_grant.
  - On entering BUSY_x, latch addr, we and wdata, and set last_grant=x.
- BUSY_x:
  - Drive mem_req=1 and mem_addr = latched addr with the low OFFSET_BITS bits zeroed.
  - mem_we = latched we (always 0 for BUSY_I); mem_wdata = latched wdata.
  - Outputs are registered and stable for the whole state; new requests are ignored.
  - On a cycle with mem_ready=1: capture mem_rdata into x_line (reads only; a write leaves x_line unchanged), pulse x_ready=1 in the next cycle, go to RELEASE.
  - mem_req goes low in that same next cycle.
- RELEASE:
  - Lasts exactly one cycle with x_ready=1, then returns to IDLE.
  - The requester must drop req in this cycle; its still-high req is not re-sampled until IDLE.
- Latency: req sampled in IDLE at edge n -> mem_req high from cycle n+1. mem_ready at cycle m -> x_ready high in cycle m+1. Minimum request-to-ready is 3 cycles (memory answering in the first BUSY cycle).
- x_line keeps its value until the next fill for the same requester.
- Requester drops req while granted: the transaction still completes and ready still pulses; there is no abort path other than reset.
- mem_ready while in IDLE or RELEASE: ignored.
- Each requester has at most one outstanding transaction; requests are never queued.

Test Plan:
- Reset release, no requests, 10 cycles -> all outputs 0, mem_req never high.
- I-cache alone:
  - Stimulus: icache_req=1, icache_addr=0x0000_1008; memory returns 0xDEADBEEF_00000003_00000002_00000001 after 3 cycles.
  - Required: mem_addr=0x0000_1000, mem_we=0; icache_ready pulses exactly one cycle with that line; dcache_ready stays 0.
- D-cache writeback:
  - Stimulus: dcache_req=1, dcache_we=1, dcache_addr=0x20, dcache_wdata=0x...0008.
  - Required: mem_we=1, mem_addr=0x20, mem_wdata matches; dcache_ready pulses once; dcache_line unchanged.
- Simultaneous requests, both held for three back-to-back transactions:
  - Required grant order I, D, I.
  - Required: no cycle with both ready signals high.
- Reset mid-transaction:
  - Stimulus: reset=0 two cycles after mem_req rises; memory's mem_ready then arrives.
  - Required: mem_req and outputs clear asynchronously; no ready pulse follows; after release, a new icache_req is granted first.
- Spurious mem_ready in IDLE -> no ready pulse, state stays IDLE; requester dropping req mid-BUSY still gets exactly one ready pulse.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Signal bundle between the I-cache/D-cache miss paths, the shared memory port and memory_arbiter.
interface memory_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_WIDTH    = 128
);
  logic                     icache_req;
  logic [ADDRESS_WIDTH-1:0] icache_addr;
  logic                     icache_ready;
  logic [LINE_WIDTH-1:0]    icache_line;

  logic                     dcache_req;
  logic                     dcache_we;
  logic [ADDRESS_WIDTH-1:0] dcache_addr;
  logic [LINE_WIDTH-1:0]    dcache_wdata;
  logic                     dcache_ready;
  logic [LINE_WIDTH-1:0]    dcache_line;

  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0]    mem_wdata;
  logic [LINE_WIDTH-1:0]    mem_rdata;
  logic                     mem_ready;

  // master: the arbiter, which owns the memory port and answers the caches
  modport master (
    input  icache_req, icache_addr,
    input  dcache_req, dcache_we, dcache_addr, dcache_wdata,
    input  mem_rdata, mem_ready,
    output icache_ready, icache_line,
    output dcache_ready, dcache_line,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output icache_req, icache_addr,
    output dcache_req, dcache_we, dcache_addr, dcache_wdata,
    output mem_rdata, mem_ready,
    input  icache_ready, icache_line,
    input  dcache_ready, dcache_line,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache fills and
// D-cache fills/writebacks; one transaction at a time, one-cycle ready pulse per requester.
module memory_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int OFFSET_BITS   = 4
) (
  input logic         clk,
  input logic         reset,
  memory_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = {ADDRESS_WIDTH{1'b1}} << OFFSET_BITS;

  state_t state, state_next;
  grant_t last_grant, grant_next;
  logic   load;
  logic   busy;

  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     we_q;
  logic [LINE_WIDTH-1:0]    wdata_q;
  logic [LINE_WIDTH-1:0]    icache_line_q;
  logic [LINE_WIDTH-1:0]    dcache_line_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
    end else begin
      state      <= state_next;
      last_grant <= grant_next;
    end
  end

  // last_grant doubles as the owner of the BUSY/RELEASE phase, so ready decodes from it
  always_comb begin
    state_next = state;
    grant_next = last_grant;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.icache_req && (!bus.dcache_req || last_grant == GRANT_D)) begin
          state_next = BUSY_I;
          grant_next = GRANT_I;
          load       = 1'b1;
        end else if (bus.dcache_req) begin
          state_next = BUSY_D;
          grant_next = GRANT_D;
          load       = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready) state_next = RELEASE;
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      icache_line_q <= '0;
      dcache_line_q <= '0;
    end else begin
      if (load) begin
        if (grant_next == GRANT_I) begin
          addr_q  <= bus.icache_addr;
          we_q    <= 1'b0;
          wdata_q <= '0;
        end else begin
          addr_q  <= bus.dcache_addr;
          we_q    <= bus.dcache_we;
          wdata_q <= bus.dcache_wdata;
        end
      end
      if (busy && bus.mem_ready && !we_q) begin
        if (state == BUSY_I) icache_line_q <= bus.mem_rdata;
        else                 dcache_line_q <= bus.mem_rdata;
      end
    end
  end

  assign busy = (state == BUSY_I) || (state == BUSY_D);

  assign bus.mem_req   = busy;
  assign bus.mem_we    = busy & we_q;
  assign bus.mem_addr  = busy ? (addr_q & LINE_MASK) : '0;
  assign bus.mem_wdata = busy ? wdata_q : '0;

  assign bus.icache_ready = (state == RELEASE) && (last_grant == GRANT_I);
  assign bus.dcache_ready = (state == RELEASE) && (last_grant == GRANT_D);
  assign bus.icache_line  = icache_line_q;
  assign bus.dcache_line  = dcache_line_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, corner-case sequences
// and a randomized run against a transaction-level reference model.
module tb_memory_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  memory_arbiter_if #(.ADDRESS_WIDTH(32), .LINE_WIDTH(128)) bus ();

  memory_arbiter #(
    .ADDRESS_WIDTH(32),
    .LINE_WIDTH(128),
    .OFFSET_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int unsigned delay;
    logic [31:0] exp_addr;
    bit          exp_we;
    logic [127:0] exp_wdata;
    logic [127:0] exp_iline;
    logic [127:0] exp_dline;
  } vec_t;

  vec_t vecs[5];

  // reference model state: owner of the current transaction and of the ready phase
  int           m_busy, m_rel;   // 0 none, 1 I-cache, 2 D-cache
  bit           m_last_i;
  logic [31:0]  m_addr;
  logic         m_we;
  logic [127:0] m_wdata, m_iline, m_dline;
  bit           i_out, d_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.icache_req   = 1'b0;
    bus.icache_addr  = '0;
    bus.dcache_req   = 1'b0;
    bus.dcache_we    = 1'b0;
    bus.dcache_addr  = '0;
    bus.dcache_wdata = '0;
    bus.mem_rdata    = '0;
    bus.mem_ready    = 1'b0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_mem_req(input string name);
    for (int n = 0; n < 8 && bus.mem_req !== 1'b1; n++) tick();
    chk(name, bus.mem_req, 1'b1);
  endtask

  task automatic complete(input string name, input logic [1:0] exp_rdy,
                          input logic [127:0] rdata, input bit drop);
    bus.mem_rdata = rdata;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk(name, {bus.icache_ready, bus.dcache_ready}, exp_rdy);
    chk({name, "_memreq_low"}, bus.mem_req, 1'b0);
    if (drop) begin
      if (exp_rdy[1]) bus.icache_req = 1'b0;
      else            bus.dcache_req = 1'b0;
    end
    tick();
    chk({name, "_one_cycle"}, {bus.icache_ready, bus.dcache_ready}, 2'b00);
  endtask

  task automatic model_step();
    bit pick_i;
    if (m_rel != 0) begin
      m_rel = 0;
    end else if (m_busy != 0) begin
      if (bus.mem_ready) begin
        if (!m_we) begin
          if (m_busy == 1) m_iline = bus.mem_rdata;
          else             m_dline = bus.mem_rdata;
        end
        m_rel  = m_busy;
        m_busy = 0;
      end
    end else begin
      pick_i = bus.icache_req && (!bus.dcache_req || !m_last_i);
      if (pick_i) begin
        m_busy = 1; m_last_i = 1'b1;
        m_addr = bus.icache_addr; m_we = 1'b0; m_wdata = '0;
      end else if (bus.dcache_req) begin
        m_busy = 2; m_last_i = 1'b0;
        m_addr = bus.dcache_addr; m_we = bus.dcache_we; m_wdata = bus.dcache_wdata;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    clear_inputs();

    vecs[0] = '{1'b0, 1'b0, 32'h0000_1008, 128'h0,
                128'hDEADBEEF_00000003_00000002_00000001, 3,
                32'h0000_1000, 1'b0, 128'h0,
                128'hDEADBEEF_00000003_00000002_00000001, 128'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 128'h8,
                128'h5555_5555_5555_5555_5555_5555_5555_5555, 1,
                32'h0000_0020, 1'b1, 128'h8,
                128'hDEADBEEF_00000003_00000002_00000001, 128'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h1234_567F, 128'h77,
                128'hA5A5_A5A5_0000_1111_2222_3333_4444_5A5A, 0,
                32'h1234_5670, 1'b0, 128'h77,
                128'hDEADBEEF_00000003_00000002_00000001,
                128'hA5A5_A5A5_0000_1111_2222_3333_4444_5A5A};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 128'h0,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0,
                32'hFFFF_FFF0, 1'b0, 128'h0,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                128'hA5A5_A5A5_0000_1111_2222_3333_4444_5A5A};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_000F, 128'hCAFE,
                {4{32'hFFFF_FFFF}}, 2,
                32'h0000_0000, 1'b1, 128'hCAFE,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                128'hA5A5_A5A5_0000_1111_2222_3333_4444_5A5A};

    // reset held: every output zero
    tick();
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 128'h0);
    chk("rst_ready", {bus.icache_ready, bus.dcache_ready, bus.mem_we}, 3'b000);
    chk("rst_lines", bus.icache_line | bus.dcache_line, 128'h0);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_quiet", {bus.mem_req, bus.mem_we, bus.icache_ready, bus.dcache_ready}, 4'b0000);
    end

    // single-requester transactions from the vector table
    for (int k = 0; k < 5; k++) begin
      v = vecs[k];
      if (v.is_d) begin
        bus.dcache_req = 1'b1; bus.dcache_we = v.we;
        bus.dcache_addr = v.addr; bus.dcache_wdata = v.wdata;
      end else begin
        bus.icache_req = 1'b1; bus.icache_addr = v.addr;
      end
      tick();
      chk("vec_req_latency", bus.mem_req, 1'b1);
      chk("vec_mem_addr", bus.mem_addr, v.exp_addr);
      chk("vec_mem_we", bus.mem_we, v.exp_we);
      chk("vec_mem_wdata", bus.mem_wdata, v.exp_wdata);
      for (int d = 0; d < int'(v.delay); d++) begin
        tick();
        chk("vec_hold", {bus.mem_req, bus.mem_addr}, {1'b1, v.exp_addr});
      end
      bus.mem_rdata = v.rdata;
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      chk("vec_ready", {bus.icache_ready, bus.dcache_ready}, v.is_d ? 2'b01 : 2'b10);
      chk("vec_memreq_low", bus.mem_req, 1'b0);
      chk("vec_iline", bus.icache_line, v.exp_iline);
      chk("vec_dline", bus.dcache_line, v.exp_dline);
      bus.icache_req = 1'b0;
      bus.dcache_req = 1'b0;
      tick();
      chk("vec_pulse_end", {bus.icache_ready, bus.dcache_ready}, 2'b00);
    end

    // spurious mem_ready while idle
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("spurious_no_ready", {bus.mem_req, bus.icache_ready, bus.dcache_ready}, 3'b000);
    tick();
    chk("spurious_stays_idle", {bus.mem_req, bus.icache_ready, bus.dcache_ready}, 3'b000);

    // requester drops req while granted
    bus.icache_req = 1'b1;
    bus.icache_addr = 32'h0000_0504;
    tick();
    chk("drop_granted", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h0000_0500});
    bus.icache_req = 1'b0;
    tick();
    tick();
    chk("drop_still_busy", bus.mem_req, 1'b1);
    complete("drop_ready", 2'b10, 128'h1357_9BDF, 1'b0);
    chk("drop_iline", bus.icache_line, 128'h1357_9BDF);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("drop_no_regrant", {bus.mem_req, bus.icache_ready}, 2'b00);
    end

    // both requesters held: grant order I, D, I
    pulse_reset();
    bus.icache_req = 1'b1; bus.icache_addr = 32'h0000_1100;
    bus.dcache_req = 1'b1; bus.dcache_addr = 32'h0000_2200; bus.dcache_we = 1'b0;
    for (int g = 0; g < 3; g++) begin
      wait_mem_req("sim_grant");
      chk("sim_order", bus.mem_addr, (g % 2 == 0) ? 32'h0000_1100 : 32'h0000_2200);
      complete("sim_ready", (g % 2 == 0) ? 2'b10 : 2'b01, 128'(g + 1), 1'b0);
    end

    // reset in the middle of an I-cache transaction
    pulse_reset();
    bus.dcache_req = 1'b1; bus.dcache_we = 1'b0; bus.dcache_addr = 32'h0000_0040;
    wait_mem_req("rmid_d_grant");
    complete("rmid_d_ready", 2'b01, 128'h1111_2222, 1'b1);
    bus.icache_req = 1'b1; bus.icache_addr = 32'h0000_0080;
    wait_mem_req("rmid_i_grant");
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rmid_async_memreq", bus.mem_req, 1'b0);
    chk("rmid_async_addr", bus.mem_addr, 32'h0);
    chk("rmid_async_lines", bus.icache_line | bus.dcache_line, 128'h0);
    bus.icache_req = 1'b0;
    bus.dcache_req = 1'b0;
    bus.mem_rdata = 128'hBAD;
    bus.mem_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("rmid_no_ready", {bus.mem_req, bus.icache_ready, bus.dcache_ready}, 3'b000);
    tick();
    chk("rmid_no_ready2", {bus.mem_req, bus.icache_ready, bus.dcache_ready}, 3'b000);
    bus.icache_req = 1'b1; bus.icache_addr = 32'h0000_0300;
    bus.dcache_req = 1'b1; bus.dcache_addr = 32'h0000_0400;
    tick();
    chk("rmid_i_first", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h0000_0300});
    complete("rmid_i_ready", 2'b10, 128'h42, 1'b1);

    // randomized traffic against the reference model
    pulse_reset();
    m_busy = 0; m_rel = 0; m_last_i = 1'b0;
    m_addr = '0; m_we = 1'b0; m_wdata = '0; m_iline = '0; m_dline = '0;
    i_out = 1'b0; d_out = 1'b0;
    for (int c = 0; c < 600; c++) begin
      model_step();
      tick();
      chk("rnd_mem_req", bus.mem_req, m_busy != 0);
      chk("rnd_mem_addr", bus.mem_addr, (m_busy != 0) ? (m_addr & 32'hFFFF_FFF0) : 32'h0);
      chk("rnd_mem_we", bus.mem_we, (m_busy != 0) ? m_we : 1'b0);
      chk("rnd_mem_wdata", bus.mem_wdata, (m_busy != 0) ? m_wdata : 128'h0);
      chk("rnd_ready", {bus.icache_ready, bus.dcache_ready}, {m_rel == 1, m_rel == 2});
      chk("rnd_iline", bus.icache_line, m_iline);
      chk("rnd_dline", bus.dcache_line, m_dline);

      if (m_rel == 1) begin
        bus.icache_req = 1'b0; i_out = 1'b0;
      end else if (!i_out && $urandom_range(0, 3) == 0) begin
        bus.icache_req = 1'b1; i_out = 1'b1; bus.icache_addr = $urandom;
      end else if (m_busy == 1 && bus.icache_req && $urandom_range(0, 7) == 0) begin
        bus.icache_req = 1'b0;
      end

      if (m_rel == 2) begin
        bus.dcache_req = 1'b0; d_out = 1'b0;
      end else if (!d_out && $urandom_range(0, 2) == 0) begin
        bus.dcache_req = 1'b1; d_out = 1'b1;
        bus.dcache_addr = $urandom;
        bus.dcache_we = $urandom_range(0, 1) == 1;
        bus.dcache_wdata = {$urandom, $urandom, $urandom, $urandom};
      end else if (m_busy == 2 && bus.dcache_req && $urandom_range(0, 7) == 0) begin
        bus.dcache_req = 1'b0;
      end

      bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (m_busy != 0) bus.mem_ready = $urandom_range(0, 2) == 0;
      else             bus.mem_ready = $urandom_range(0, 7) == 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
